// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and op classification for alu_seq.
// ALU_MUL_EN adds MUL to the iterative op set.
package alu_pkg;
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_NOR   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_NOT   = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_CLEAR = 4'b0111;
    localparam logic [3:0] OP_SHL   = 4'b1000;
    localparam logic [3:0] OP_SHR   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    function automatic logic op_is_iterative(input logic [3:0] op);
`ifdef ALU_MUL_EN
        return op == OP_SHL || op == OP_SHR || op == OP_MUL;
`else
        return op == OP_SHL || op == OP_SHR;
`endif
    endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand-issue and result handshake bundle for alu_seq.
interface alu_seq_if #(parameter int WIDTH = 8);
    logic             in_valid, in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] result;
    logic             cout, zero, neg, ovf, err;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, result, cout, zero, neg, ovf, err
    );
    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, result, cout, zero, neg, ovf, err
    );
endinterface

// File: rtl/alu_comb.sv
// alu_comb: single-cycle ALU datapath (ADD..CLEAR) with carry, overflow and error flags.
module alu_comb import alu_pkg::*; #(parameter int WIDTH = 8) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf,
    output logic             err
);
    logic             sub;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   sum;

    assign sub = op == OP_SUB;
    assign bb  = sub ? ~b : b;
    assign sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub ? 1'b1 : cin};

    always_comb begin
        res  = '0;
        cout = 1'b0;
        ovf  = 1'b0;
        err  = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res  = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   res = a & b;
            OP_NOR:   res = ~(a | b);
            OP_OR:    res = a | b;
            OP_NOT:   res = ~a;
            OP_XOR:   res = a ^ b;
            OP_CLEAR: res = '0;
            // only zero-amount shifts take the single-cycle path
            OP_SHL, OP_SHR: res = a;
            default:  err = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with bit-serial shifts and optional shift-add MUL.
// Define ALU_MUL_EN to build the MUL datapath; otherwise opcode 1010 reports err.
module alu_seq import alu_pkg::*; #(parameter int WIDTH = 8) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = $clog2(WIDTH + 1);

    state_t             state;
    logic [3:0]         iop;
    logic [WIDTH-1:0]   acc, c_res, step_res, fin_res;
    logic [CNT_W-1:0]   cnt;
    logic [SHAMT_W-1:0] amt;
    logic               c_cout, c_ovf, c_err, step_c, accept, go_iter, last_step, load_out;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op(bus.op), .a(bus.a), .b(bus.b), .cin(bus.cin),
        .res(c_res), .cout(c_cout), .ovf(c_ovf), .err(c_err)
    );

    assign bus.in_ready  = !rst && (state == S_IDLE || (state == S_DONE && bus.out_ready));
    assign bus.out_valid = state == S_DONE;
    assign accept        = bus.in_valid && bus.in_ready;
    assign amt           = bus.b[SHAMT_W-1:0];
    assign go_iter       = op_is_iterative(bus.op) && (bus.op == OP_MUL || amt != '0);
    assign last_step     = state == S_BUSY && cnt == CNT_W'(1);
    assign load_out      = (accept && !go_iter) || last_step;
    assign fin_res       = last_step ? step_res : c_res;

`ifdef ALU_MUL_EN
    // {hi, acc} is the product register: acc starts as b, hi accumulates a each set bit
    logic [WIDTH-1:0] hi, hi_n, m, mul_lo;
    logic [WIDTH:0]   psum;

    assign psum = {1'b0, hi} + {1'b0, m};
    assign {hi_n, mul_lo} = acc[0] ? {psum, acc[WIDTH-1:1]} : {1'b0, hi, acc[WIDTH-1:1]};
    assign step_res = iop == OP_MUL ? mul_lo :
                      iop == OP_SHL ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};
    assign step_c   = iop == OP_MUL ? |hi_n : iop == OP_SHL ? acc[WIDTH-1] : acc[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            m  <= '0;
        end else if (accept) begin
            hi <= '0;
            m  <= bus.a;
        end else if (state == S_BUSY) begin
            hi <= hi_n;
        end
    end
`else
    assign step_res = iop == OP_SHL ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};
    assign step_c   = iop == OP_SHL ? acc[WIDTH-1] : acc[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            iop        <= '0;
            acc        <= '0;
            cnt        <= '0;
            bus.result <= '0;
            bus.cout   <= 1'b0;
            bus.zero   <= 1'b0;
            bus.neg    <= 1'b0;
            bus.ovf    <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            if (accept) begin
                iop   <= bus.op;
                acc   <= bus.op == OP_MUL ? bus.b : bus.a;
                cnt   <= bus.op == OP_MUL ? CNT_W'(WIDTH) : CNT_W'(amt);
                state <= go_iter ? S_BUSY : S_DONE;
            end else if (state == S_BUSY) begin
                acc   <= step_res;
                cnt   <= cnt - CNT_W'(1);
                state <= last_step ? S_DONE : S_BUSY;
            end else if (state == S_DONE && bus.out_ready) begin
                state <= S_IDLE;
            end
            if (load_out) begin
                bus.result <= fin_res;
                bus.cout   <= last_step ? step_c : c_cout;
                bus.zero   <= fin_res == '0;
                bus.neg    <= fin_res[WIDTH-1];
                bus.ovf    <= !last_step && c_ovf;
                bus.err    <= !last_step && c_err;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq at WIDTH=4.
// Honours ALU_MUL_EN so the same bench checks both builds.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct packed {
        logic [3:0] res;
        logic       cout, zero, neg, ovf, err;
    } exp_t;

    logic clk, rst;
    int   n_asrt = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t last;

    alu_seq_if #(.WIDTH(4)) bus ();
    alu_seq #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                                   input logic cin);
        exp_t e;
        int ua, ub, sa, sb, s, amt;
        e   = '0;
        ua  = int'(a);
        ub  = int'(b);
        sa  = ua > 7 ? ua - 16 : ua;
        sb  = ub > 7 ? ub - 16 : ub;
        amt = ub % 4;
        s   = 0;
        case (op)
            OP_ADD: begin
                s      = ua + ub + int'(cin);
                e.cout = s > 15;
                e.ovf  = (sa + sb + int'(cin) > 7) || (sa + sb + int'(cin) < -8);
            end
            OP_SUB: begin
                s      = ua - ub;
                e.cout = ua >= ub;
                e.ovf  = (sa - sb > 7) || (sa - sb < -8);
            end
            OP_AND:   s = ua & ub;
            OP_NOR:   s = ~(ua | ub);
            OP_OR:    s = ua | ub;
            OP_NOT:   s = ~ua;
            OP_XOR:   s = ua ^ ub;
            OP_CLEAR: s = 0;
            OP_SHL: begin
                s      = ua << amt;
                e.cout = ((ua >> (4 - amt)) & 1) == 1;
            end
            OP_SHR: begin
                s      = ua >> amt;
                e.cout = amt == 0 ? 1'b0 : ((ua >> (amt - 1)) & 1) == 1;
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                s      = ua * ub;
                e.cout = s > 15;
            end
`endif
            default: e.err = 1'b1;
        endcase
        e.res  = 4'(s);
        e.zero = e.res == 4'd0;
        e.neg  = e.res[3];
        return e;
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [3:0] b);
        int amt;
        amt = int'(b) % 4;
        if (op == OP_SHL || op == OP_SHR) return amt + 1;
`ifdef ALU_MUL_EN
        if (op == OP_MUL) return 5;
`endif
        return 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic cin);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        #1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept_wait", 32'(n < 20), 32'(1));
        q.push_back(model(op, a, b, cin));
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int lat_exp);
        int lat;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(lat_exp));
        check({tag, ".sb_nonempty"}, 32'(q.size() > 0), 32'(1));
        if (q.size() > 0) begin
            last = q.pop_front();
            check({tag, ".result"}, 32'(bus.result), 32'(last.res));
            check({tag, ".cout"}, 32'(bus.cout), 32'(last.cout));
            check({tag, ".zero"}, 32'(bus.zero), 32'(last.zero));
            check({tag, ".neg"}, 32'(bus.neg), 32'(last.neg));
            check({tag, ".ovf"}, 32'(bus.ovf), 32'(last.ovf));
            check({tag, ".err"}, 32'(bus.err), 32'(last.err));
        end
    endtask

    task automatic ack;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic cin);
        send(op, a, b, cin);
        wait_out(tag, exp_lat(op, b));
        ack();
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = 4'd0;
        bus.a = 4'd0;
        bus.b = 4'd0;
        bus.cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.in_ready", 32'(bus.in_ready), 32'(0));
        check("rst.out_valid", 32'(bus.out_valid), 32'(0));
        check("rst.result", 32'(bus.result), 32'(0));
        check("rst.flags", 32'({bus.cout, bus.zero, bus.neg, bus.ovf, bus.err}), 32'(0));
        rst = 1'b0;
        #1;
        check("idle.in_ready", 32'(bus.in_ready), 32'(1));

        run("add_ovf", OP_ADD, 4'b1011, 4'b1001, 1'b1);
        run("add_pos_ovf", OP_ADD, 4'b0111, 4'b0001, 1'b0);
        run("add_nocin", OP_ADD, 4'b0010, 4'b0011, 1'b0);
        run("sub_borrow", OP_SUB, 4'b0011, 4'b0101, 1'b1);
        run("sub_zero", OP_SUB, 4'b0101, 4'b0101, 1'b0);
        run("sub_ovf", OP_SUB, 4'b1000, 4'b0001, 1'b0);
        run("and", OP_AND, 4'b1100, 4'b1010, 1'b1);
        run("nor", OP_NOR, 4'b1100, 4'b1010, 1'b0);
        run("or", OP_OR, 4'b0100, 4'b0010, 1'b0);
        run("not", OP_NOT, 4'b1010, 4'b0000, 1'b0);
        run("xor", OP_XOR, 4'b1111, 4'b1111, 1'b1);
        run("clear", OP_CLEAR, 4'b1111, 4'b1111, 1'b1);
        run("shl2", OP_SHL, 4'b0011, 4'b0010, 1'b0);
        run("shr1", OP_SHR, 4'b1001, 4'b0001, 1'b0);
        run("shl0", OP_SHL, 4'b0110, 4'b0000, 1'b0);
        run("shl3", OP_SHL, 4'b1111, 4'b0011, 1'b0);
        run("shr3", OP_SHR, 4'b1000, 4'b0011, 1'b0);
        run("shr_hi_b", OP_SHR, 4'b1011, 4'b0110, 1'b0);
        run("mul_a", OP_MUL, 4'b0101, 4'b0011, 1'b0);
        run("mul_b", OP_MUL, 4'b0110, 4'b0011, 1'b0);
        run("undef_f", 4'b1111, 4'b0101, 4'b0011, 1'b0);
        run("undef_b", 4'b1011, 4'b0001, 4'b0001, 1'b1);

        // hold DONE for 5 clocks while a new op waits, then consume and accept together
        send(OP_ADD, 4'b0110, 4'b0111, 1'b0);
        wait_out("stall", 1);
        bus.in_valid = 1'b1;
        bus.op = OP_XOR;
        bus.a = 4'b1010;
        bus.b = 4'b0110;
        bus.cin = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("stall.result", 32'(bus.result), 32'(last.res));
            check("stall.flags", 32'({bus.cout, bus.zero, bus.neg, bus.ovf, bus.err}),
                  32'({last.cout, last.zero, last.neg, last.ovf, last.err}));
            check("stall.in_ready", 32'(bus.in_ready), 32'(0));
            check("stall.out_valid", 32'(bus.out_valid), 32'(1));
        end
        bus.out_ready = 1'b1;
        #1;
        check("b2b.in_ready", 32'(bus.in_ready), 32'(1));
        q.push_back(model(OP_XOR, 4'b1010, 4'b0110, 1'b0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        wait_out("b2b", 1);
        ack();

        // reset while the iterator is mid-operation
`ifdef ALU_MUL_EN
        send(OP_MUL, 4'b0111, 4'b0111, 1'b0);
`else
        send(OP_SHL, 4'b0001, 4'b0011, 1'b0);
`endif
        @(negedge clk);
        check("busy.out_valid", 32'(bus.out_valid), 32'(0));
        rst = 1'b1;
        #1;
        check("busy_rst.in_ready", 32'(bus.in_ready), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        check("busy_rst.out_valid", 32'(bus.out_valid), 32'(0));
        check("busy_rst.result", 32'(bus.result), 32'(0));
        check("busy_rst.flags", 32'({bus.cout, bus.zero, bus.neg, bus.ovf, bus.err}), 32'(0));
        #1;
        check("busy_rst.in_ready", 32'(bus.in_ready), 32'(1));
        repeat (6) @(negedge clk);
        check("busy_rst.discarded", 32'(bus.out_valid), 32'(0));
        run("add_after_rst", OP_ADD, 4'b1011, 4'b1001, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
